// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch front end.
package ifu_pkg;

  localparam int XLEN   = 64;
  localparam int INST_W = 32;

  localparam logic [XLEN-1:0] RESET_PC = 64'h8000_0000;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_sync_fifo.sv
// Small synchronous FIFO with a flush input; head data is read combinationally
// so a pushed entry is visible the cycle after the push edge.
module ifu_sync_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head_data,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0] count_reg, count_next;
  logic          do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_push = push && (count_reg != CW'(DEPTH));
  assign do_pop  = pop && (count_reg != '0);

  always_comb begin
    count_next = count_reg;
    if (do_push && !do_pop) count_next = count_reg + 1'b1;
    if (!do_push && do_pop) count_next = count_reg - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      count_reg <= count_next;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr_reg] <= push_data;
  end

  assign head_data = mem[rd_ptr_reg];
  assign count     = count_reg;

endmodule

// File: rtl/ifu_prefetch.sv
// Fetch PC, request issue with credit limiting, response tracking and a
// prefetch FIFO feeding decode; redirects flush and drop in-flight responses.
module ifu_prefetch
  import ifu_pkg::*;
#(
  parameter logic [63:0] RESET_PC = ifu_pkg::RESET_PC,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  input  logic        stall,
  output logic        inst_valid,
  output logic [63:0] inst_pc,
  output logic [31:0] inst
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [63:0]   fetch_pc_reg, fetch_pc_next;
  logic [CW-1:0] inflight_reg, inflight_next;
  logic [CW-1:0] drop_reg, drop_next;
  logic [CW-1:0] count, pcq_count;
  logic [CW:0]   credit_sum;
  logic [63:0]   pcq_head;
  fetch_entry_t  push_entry, head_entry;
  logic          issue, resp_live, drop_dec, pop;

  assign credit_sum     = {1'b0, count} + {1'b0, inflight_reg};
  assign imem_req_valid = !rst && !redirect && (credit_sum < (CW + 1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_reg;
  assign issue          = imem_req_valid && imem_req_ready;

  // The PC queue mirrors inflight; requiring both keeps a stray response
  // from ever popping an empty queue.
  assign drop_dec  = imem_resp_valid && (drop_reg != '0);
  assign resp_live = imem_resp_valid && (drop_reg == '0) &&
                     (inflight_reg != '0) && (pcq_count != '0);

  assign inst_valid = (count != '0);
  assign pop        = inst_valid && !stall && !redirect;

  assign push_entry.pc   = pcq_head;
  assign push_entry.inst = imem_resp_data;

  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    inflight_next = inflight_reg + CW'(issue) - CW'(resp_live);
    drop_next     = drop_reg - CW'(drop_dec);
    if (issue) fetch_pc_next = fetch_pc_reg + 64'd4;
    if (redirect) begin
      // A live response landing with the redirect is stale too, so it is
      // consumed here rather than counted as one more to drop.
      fetch_pc_next = word_align(redirect_pc);
      inflight_next = '0;
      drop_next     = drop_reg - CW'(drop_dec) + inflight_reg - CW'(resp_live);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_reg <= RESET_PC;
      inflight_reg <= '0;
      drop_reg     <= '0;
    end else begin
      fetch_pc_reg <= fetch_pc_next;
      inflight_reg <= inflight_next;
      drop_reg     <= drop_next;
    end
  end

  ifu_sync_fifo #(.W(64), .DEPTH(DEPTH)) u_pc_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (issue),
    .push_data (fetch_pc_reg),
    .pop       (resp_live),
    .head_data (pcq_head),
    .count     (pcq_count)
  );

  ifu_sync_fifo #(.W($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_entry_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (resp_live && !redirect),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_entry),
    .count     (count)
  );

  assign inst_pc = inst_valid ? head_entry.pc   : '0;
  assign inst    = inst_valid ? head_entry.inst : '0;

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch with a latency-configurable in-order memory model.
module tb_ifu_prefetch;

  logic        clk, rst;
  logic        imem_req_valid, imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect, stall;
  logic [63:0] redirect_pc;
  logic        inst_valid;
  logic [63:0] inst_pc;
  logic [31:0] inst;

  int n_checks = 0;
  int n_pass   = 0;
  int n_pop    = 0;
  int n_acc    = 0;
  int lat      = 1;
  logic [63:0] exp_pc, exp_req;
  logic        pv [1:3];
  logic [63:0] pa [1:3];

  localparam logic [63:0] RST_PC = 64'h8000_0000;

  ifu_prefetch #(.RESET_PC(RST_PC), .DEPTH(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .stall           (stall),
    .inst_valid      (inst_valid),
    .inst_pc         (inst_pc),
    .inst            (inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'h0000_0013;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else begin
      n_pass++;
      $display("ok   %s = %h", tag, got);
    end
  endtask

  // One clock cycle: check any pop and any accepted request, then advance the
  // memory pipeline and present the response due in the next cycle.
  task automatic tick();
    logic        acc;
    logic [63:0] a;
    #1;
    if (!rst && inst_valid && !stall && !redirect) begin
      check("pop_pc", inst_pc, exp_pc);
      check("pop_inst", {32'h0, inst}, {32'h0, mem_word(exp_pc)});
      exp_pc = exp_pc + 64'd4;
      n_pop++;
    end
    acc = imem_req_valid && imem_req_ready;
    a   = imem_req_addr;
    if (acc) begin
      check("req_addr", a, exp_req);
      exp_req = exp_req + 64'd4;
      n_acc++;
    end
    @(posedge clk);
    @(negedge clk);
    pv[3] = pv[2]; pa[3] = pa[2];
    pv[2] = pv[1]; pa[2] = pa[1];
    pv[1] = acc && !rst; pa[1] = a;
    imem_resp_valid = pv[lat] && !rst;
    imem_resp_data  = mem_word(pa[lat]);
  endtask

  task automatic drain();
    imem_req_ready = 1'b0;
    stall = 1'b0;
    repeat (8) tick();
    check("drain_empty", inst_valid, 1'b0);
  endtask

  initial begin
    rst = 1'b1; imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = '0;
    redirect = 1'b0; redirect_pc = '0; stall = 1'b0;
    for (int i = 1; i <= 3; i++) begin pv[i] = 1'b0; pa[i] = '0; end
    exp_pc = RST_PC; exp_req = RST_PC;

    #2;
    check("rst_req_valid", imem_req_valid, 1'b0);
    check("rst_req_addr", imem_req_addr, RST_PC);
    check("rst_inst_valid", inst_valid, 1'b0);
    check("rst_inst_pc", inst_pc, 64'h0);
    check("rst_inst", {32'h0, inst}, 64'h0);
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check("first_req_valid", imem_req_valid, 1'b1);
    check("first_req_addr", imem_req_addr, 64'h8000_0000);

    // Steady stream, 1-cycle latency
    tick();
    check("stream_lat0", inst_valid, 1'b0);
    tick();
    check("stream_first_valid", inst_valid, 1'b1);
    check("stream_first_pc", inst_pc, 64'h8000_0000);
    n_pop = 0;
    repeat (6) tick();
    check("stream_rate", 64'(n_pop), 64'd6);
    check("stream_valid", inst_valid, 1'b1);

    // Backpressure: credit caps buffered + outstanding at 4
    stall = 1'b1; n_acc = 0;
    repeat (10) tick();
    check("bp_issued", 64'(n_acc), 64'd2);
    check("bp_req_blocked", imem_req_valid, 1'b0);
    check("bp_head_pc", inst_pc, 64'h8000_0018);
    stall = 1'b0; n_pop = 0;
    repeat (8) tick();
    check("bp_release_rate", 64'(n_pop), 64'd8);
    drain();

    // Redirect with two requests in flight, 3-cycle latency
    lat = 3; imem_req_ready = 1'b1;
    tick();
    tick();
    redirect = 1'b1; redirect_pc = 64'h8000_0102;
    exp_pc = 64'h8000_0100; exp_req = 64'h8000_0100;
    #1;
    check("redir_req_blocked", imem_req_valid, 1'b0);
    tick();
    redirect = 1'b0;
    #1;
    check("redir_next_valid", imem_req_valid, 1'b1);
    check("redir_next_addr", imem_req_addr, 64'h8000_0100);
    check("redir_empty", inst_valid, 1'b0);
    repeat (4) tick();
    check("redir_first_valid", inst_valid, 1'b1);
    check("redir_first_pc", inst_pc, 64'h8000_0100);
    drain();
    lat = 1;

    // Redirect coinciding with a live response and a would-be pop
    imem_req_ready = 1'b1;
    tick();
    tick();
    check("sim_pre_valid", inst_valid, 1'b1);
    redirect = 1'b1; redirect_pc = 64'h8000_0200;
    exp_pc = 64'h8000_0200; exp_req = 64'h8000_0200;
    tick();
    redirect = 1'b0;
    #1;
    check("sim_flushed", inst_valid, 1'b0);
    check("sim_next_addr", imem_req_addr, 64'h8000_0200);
    tick();
    check("sim_discard", inst_valid, 1'b0);
    tick();
    check("sim_first_pc", inst_pc, 64'h8000_0200);

    // Fetch PC wrap-around
    redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    exp_pc = 64'hFFFF_FFFF_FFFF_FFFC; exp_req = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    redirect = 1'b0;
    #1;
    check("wrap_addr0", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    check("wrap_addr1", imem_req_addr, 64'h0);
    repeat (4) tick();
    drain();

    // Asynchronous reset with three requests in flight
    lat = 3; imem_req_ready = 1'b1;
    repeat (4) tick();
    check("arst_pre_valid", inst_valid, 1'b1);
    #2;
    rst = 1'b1;
    imem_resp_valid = 1'b0;
    for (int i = 1; i <= 3; i++) pv[i] = 1'b0;
    #1;
    check("arst_inst_valid", inst_valid, 1'b0);
    check("arst_req_valid", imem_req_valid, 1'b0);
    check("arst_inst_pc", inst_pc, 64'h0);
    tick();
    tick();
    rst = 1'b0; lat = 1;
    exp_pc = RST_PC; exp_req = RST_PC;
    #1;
    check("arst_restart_valid", imem_req_valid, 1'b1);
    check("arst_restart_addr", imem_req_addr, RST_PC);
    n_pop = 0;
    repeat (4) tick();
    check("arst_restart_pops", 64'(n_pop), 64'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
